// File: rtl/oai_vector_sequencer.sv
// oai_vector_sequencer
//
// Drives a shared {a,b,c} stimulus into three OAI21 cell implementations
// (switch-level, NOR-gate, boolean-algebra), holds each vector for
// SETTLE_CYCLES clocks so the cells can settle, then samples the three
// outputs and compares them against y = ~((a | b) & c).
//
// Parameters:
//   SETTLE_CYCLES  clocks each vector is held before sampling (>= 1)
//   CNT_W          width of the saturating error counter
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   start             run request, accepted only in IDLE
//   mode              0 = exhaustive 0..7, 1 = single vector vec_in
//   vec_in            single-mode vector, {a,b,c}
//   a_out/b_out/c_out registered stimulus
//   y_sw/y_nor/y_bool cell outputs under test
//   busy              high while settling or sampling
//   done              one-cycle pulse at end of run
//   err_count         mismatching vectors in this run (saturating)
//   first_err_valid   at least one mismatch recorded
//   first_err_vec     first mismatching vector
//
// Optional feature: define OAI_STOP_ON_ERR_EN to end the run at the first
// mismatching vector.

module oai_vector_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [2:0]       vec_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  input  logic             y_sw,
  input  logic             y_nor,
  input  logic             y_bool,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    CNT_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state, state_next;
  logic [2:0]      vec, vec_next;
  logic [SW-1:0]   cnt, cnt_next;
  logic            mode_q, mode_next;
  logic [CNT_W-1:0] err_next;
  logic            fev_next;
  logic [2:0]      fe_vec_next;

  logic golden;
  logic mismatch;
  logic stop_early;

  assign golden = ~((vec[2] | vec[1]) & vec[0]);

  // Case inequality so an X/Z cell output is reported as a mismatch.
  assign mismatch = (y_sw !== golden) | (y_nor !== golden) | (y_bool !== golden);

`ifdef OAI_STOP_ON_ERR_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values computed by the combinational block.
  // All registers are reset; there is no storage array here that could be
  // left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= 3'd0;
      cnt             <= '0;
      mode_q          <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 3'd0;
    end else begin
      state           <= state_next;
      vec             <= vec_next;
      cnt             <= cnt_next;
      mode_q          <= mode_next;
      err_count       <= err_next;
      first_err_valid <= fev_next;
      first_err_vec   <= fe_vec_next;
    end
  end

  // NOTE: every signal written here gets a hold default first so no path
  // through the case statement leaves one unassigned (which would infer a
  // latch).
  always_comb begin
    state_next  = state;
    vec_next    = vec;
    cnt_next    = cnt;
    mode_next   = mode_q;
    err_next    = err_count;
    fev_next    = first_err_valid;
    fe_vec_next = first_err_vec;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          err_next    = '0;
          fev_next    = 1'b0;
          fe_vec_next = 3'd0;
          vec_next    = mode ? vec_in : 3'd0;
          mode_next   = mode;
          cnt_next    = CNT_RELOAD;
          state_next  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt == '0) state_next = S_SAMPLE;
        else           cnt_next   = cnt - SW'(1);
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_next = err_count + CNT_W'(1);
          if (!first_err_valid) begin
            fev_next    = 1'b1;
            fe_vec_next = vec;
          end
        end
        if (mode_q || (vec == 3'd7) || stop_early) begin
          state_next = S_DONE;
        end else begin
          vec_next   = vec + 3'd1;
          cnt_next   = CNT_RELOAD;
          state_next = S_SETTLE;
        end
      end

      S_DONE: state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

  assign a_out = vec[2];
  assign b_out = vec[1];
  assign c_out = vec[0];
  assign busy  = (state == S_SETTLE) || (state == S_SAMPLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_oai_vector_sequencer.sv
// Directed testbench for oai_vector_sequencer. Behavioural OAI21 cells are
// built from the DUT stimulus with optional stuck-at faults. A second DUT
// instance with CNT_W=2 exercises error-counter saturation.
// Define OAI_STOP_ON_ERR_EN for both DUT and bench to check the early stop.

module tb_oai_vector_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start, start2;
  logic mode;
  logic [2:0] vec_in;

  logic a, b, c;
  logic y_sw, y_nor, y_bool;
  logic busy, done, fev;
  logic [3:0] err;
  logic [2:0] fe_vec;
  logic sw_s1, nor_s0;

  logic a2, b2, c2;
  logic y2_good;
  logic busy2, done2, fev2;
  logic [1:0] err2;
  logic [2:0] fe_vec2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural cells; the bench's own golden reference.
  assign y_sw    = sw_s1  ? 1'b1 : ~((a | b) & c);
  assign y_nor   = nor_s0 ? 1'b0 : ~((a | b) & c);
  assign y_bool  = ~((a | b) & c);
  assign y2_good = ~((a2 | b2) & c2);

  oai_vector_sequencer #(.SETTLE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .vec_in(vec_in),
    .a_out(a), .b_out(b), .c_out(c),
    .y_sw(y_sw), .y_nor(y_nor), .y_bool(y_bool),
    .busy(busy), .done(done), .err_count(err),
    .first_err_valid(fev), .first_err_vec(fe_vec)
  );

  oai_vector_sequencer #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .mode(1'b0), .vec_in(3'd0),
    .a_out(a2), .b_out(b2), .c_out(c2),
    .y_sw(y2_good), .y_nor(y2_good), .y_bool(1'b0),
    .busy(busy2), .done(done2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fe_vec2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then step off the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests a run; returns 1 ns after acceptance edge E0.
  task automatic start_run(input logic m, input logic [2:0] v);
    mode   = m;
    vec_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Exhaustive run expected to cover nvec vectors and end in DONE at E0+5*nvec.
  task automatic exh_run(input string tag, input int nvec, input int exp_err,
                         input logic exp_fev, input logic [2:0] exp_fevec);
    start_run(1'b0, 3'd0);
    check({tag, " busy@E0"}, 8'(busy), 8'd1);
    for (int k = 0; k < nvec; k++) begin
      check($sformatf("%s abc@v%0d", tag, k), 8'({a, b, c}), 8'(k));
      repeat (4) tick();
      check($sformatf("%s done_low@v%0d", tag, k), 8'(done), 8'd0);
      tick();
    end
    check({tag, " done"},      8'(done),   8'd1);
    check({tag, " busy_end"},  8'(busy),   8'd0);
    check({tag, " err_count"}, 8'(err),    8'(exp_err));
    check({tag, " fev"},       8'(fev),    8'(exp_fev));
    check({tag, " fe_vec"},    8'(fe_vec), 8'(exp_fevec));
    tick();
    check({tag, " done_pulse"}, 8'(done), 8'd0);
  endtask

  initial begin
    int done_seen;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 1'b0;
    vec_in = 3'd0;
    sw_s1  = 1'b0;
    nor_s0 = 1'b0;

    // Reset state
    #12;
    check("rst abc",    8'({a, b, c}), 8'd0);
    check("rst busy",   8'(busy),      8'd0);
    check("rst done",   8'(done),      8'd0);
    check("rst err",    8'(err),       8'd0);
    check("rst fev",    8'(fev),       8'd0);
    check("rst fe_vec", 8'(fe_vec),    8'd0);
    rst = 1'b0;
    tick();
    check("idle busy", 8'(busy), 8'd0);

    // Exhaustive, all cells correct
    exh_run("clean", 8, 0, 1'b0, 3'd0);

    // NOR cell stuck at 0: golden is 1 on vectors 0,1,2,4,6
    nor_s0 = 1'b1;
`ifdef OAI_STOP_ON_ERR_EN
    exh_run("nor_s0", 1, 1, 1'b1, 3'd0);
`else
    exh_run("nor_s0", 8, 5, 1'b1, 3'd0);
`endif
    nor_s0 = 1'b0;

    // Switch-level cell stuck at 1: golden is 0 on vectors 3,5,7
    sw_s1 = 1'b1;
`ifdef OAI_STOP_ON_ERR_EN
    exh_run("sw_s1", 4, 1, 1'b1, 3'd3);
`else
    exh_run("sw_s1", 8, 3, 1'b1, 3'd3);
`endif
    sw_s1 = 1'b0;

    // Single vector 101, extra start and input changes while busy
    start_run(1'b1, 3'b101);
    check("single abc@E0",   8'({a, b, c}), 8'b101);
    check("single err_clr",  8'(err),       8'd0);
    check("single fev_clr",  8'(fev),       8'd0);
    mode   = 1'b0;
    vec_in = 3'b010;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("single abc@E1",   8'({a, b, c}), 8'b101);
    check("single busy@E1",  8'(busy),      8'd1);
    repeat (3) tick();
    check("single done@E4",  8'(done),      8'd0);
    tick();
    check("single done@E5",  8'(done),      8'd1);
    check("single abc@E5",   8'({a, b, c}), 8'b101);
    check("single err",      8'(err),       8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start done", 8'(done),      8'd0);
    check("done_start busy", 8'(busy),      8'd0);
    tick();
    check("idle hold busy",  8'(busy),      8'd0);
    check("idle hold abc",   8'({a, b, c}), 8'b101);

    // Saturation on the CNT_W=2 instance: five mismatches
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (39) tick();
    check("sat done@39", 8'(done2), 8'd0);
    tick();
    check("sat done@40", 8'(done2), 8'd1);
`ifdef OAI_STOP_ON_ERR_EN
    check("sat err", 8'(err2), 8'd1);
`else
    check("sat err", 8'(err2), 8'd3);
`endif
    check("sat fev",    8'(fev2),    8'd1);
    check("sat fe_vec", 8'(fe_vec2), 8'd0);
    tick();

    // Reset mid-run, then a clean rerun
    start_run(1'b0, 3'd0);
    repeat (12) tick();
    check("pre_rst abc",  8'({a, b, c}), 8'b010);
    check("pre_rst busy", 8'(busy),      8'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst abc",  8'({a, b, c}), 8'd0);
    check("mid_rst busy", 8'(busy),      8'd0);
    check("mid_rst done", 8'(done),      8'd0);
    check("mid_rst err",  8'(err),       8'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("no_done_after_rst", 8'(done_seen), 8'd0);
    exh_run("rerun", 8, 0, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
